// File: rtl/axi_lite_timer_if.sv
// AXI4-Lite slave-port bundle for the timer peripheral.
// The slave modport is the timer side and the master modport is the interconnect or bench side.
interface axi_lite_timer_if;
    logic [31:0] s_awaddr;
    logic [2:0]  s_awprot;
    logic        s_awvalid;
    logic        s_awready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_wvalid;
    logic        s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready;
    logic [31:0] s_araddr;
    logic [2:0]  s_arprot;
    logic        s_arvalid;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid;
    logic        s_rready;

    modport slave (
        input  s_awaddr, s_awprot, s_awvalid,
        output s_awready,
        input  s_wdata, s_wstrb, s_wvalid,
        output s_wready,
        output s_bresp, s_bvalid,
        input  s_bready,
        input  s_araddr, s_arprot, s_arvalid,
        output s_arready,
        output s_rdata, s_rresp, s_rvalid,
        input  s_rready
    );

    modport master (
        output s_awaddr, s_awprot, s_awvalid,
        input  s_awready,
        output s_wdata, s_wstrb, s_wvalid,
        input  s_wready,
        input  s_bresp, s_bvalid,
        output s_bready,
        output s_araddr, s_arprot, s_arvalid,
        input  s_arready,
        input  s_rdata, s_rresp, s_rvalid,
        output s_rready
    );
endinterface

// File: rtl/axi_lite_timer.sv
// AXI4-Lite timer/compare peripheral: a prescaled free-running counter, a compare match flag,
// optional auto-reload, and a level interrupt.
module axi_lite_timer #(
    parameter int unsigned PRESCALE  = 16,
    parameter logic [31:0] CMP_RESET = 32'hFFFF_FFFF
) (
    input  logic              clk,
    input  logic              rst_n,
    axi_lite_timer_if.slave   bus,
    output logic              irq,
    output logic              wr_state_dbg,
    output logic              rd_state_dbg
);
    // Handshake rule: a transfer occurs on a clock edge where valid and ready are both high.
    // The slave holds bvalid and rvalid, together with rdata, until the matching ready is seen.

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;

    logic          live;
    logic          awready, wready, bvalid, wr_fire;
    logic          arready, rvalid, ar_fire;
    logic [31:0]   rdata_q, rd_value;
    logic [2:0]    ctrl;
    logic [31:0]   count, cmp;
    logic          match;
    logic [PW-1:0] presc;
    logic          tick;
    logic [1:0]    waddr, raddr;
    logic [31:0]   wr_old, wr_merged;
    logic          unused_bits;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old, input logic [31:0] din,
                                                input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) r[i*8 +: 8] = din[i*8 +: 8];
        end
        return r;
    endfunction

    assign waddr = bus.s_awaddr[3:2];
    assign raddr = bus.s_araddr[3:2];
    assign unused_bits = ^{bus.s_awaddr[31:4], bus.s_awaddr[1:0], bus.s_araddr[31:4],
                           bus.s_araddr[1:0], bus.s_awprot, bus.s_arprot};

    // Keeps every ready low while reset is asserted, even if a master holds its valids high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) live <= 1'b0;
        else        live <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) w_state <= W_IDLE;
        else        w_state <= w_next;
    end

    always_comb begin
        w_next  = w_state;
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        wr_fire = 1'b0;
        case (w_state)
            W_IDLE: begin
                if (live && bus.s_awvalid && bus.s_wvalid) begin
                    awready = 1'b1;
                    wready  = 1'b1;
                    wr_fire = 1'b1;
                    w_next  = W_RESP;
                end
            end
            W_RESP: begin
                bvalid = 1'b1;
                if (bus.s_bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= R_IDLE;
        else        r_state <= r_next;
    end

    always_comb begin
        r_next  = r_state;
        arready = 1'b0;
        rvalid  = 1'b0;
        ar_fire = 1'b0;
        case (r_state)
            R_IDLE: begin
                arready = live;
                if (live && bus.s_arvalid) begin
                    ar_fire = 1'b1;
                    r_next  = R_DATA;
                end
            end
            R_DATA: begin
                rvalid = 1'b1;
                if (bus.s_rready) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_comb begin
        rd_value = 32'h0;
        case (raddr)
            2'd0: rd_value = {29'h0, ctrl};
            2'd1: rd_value = count;
            2'd2: rd_value = cmp;
            2'd3: rd_value = {31'h0, match};
            default: rd_value = 32'h0;
        endcase
    end

    // Sampling at the accept edge returns pre-write state when a write lands on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       rdata_q <= 32'h0;
        else if (ar_fire) rdata_q <= rd_value;
    end

    always_comb begin
        wr_old = 32'h0;
        case (waddr)
            2'd0: wr_old = {29'h0, ctrl};
            2'd1: wr_old = count;
            2'd2: wr_old = cmp;
            2'd3: wr_old = {31'h0, match};
            default: wr_old = 32'h0;
        endcase
        wr_merged = merge_bytes(wr_old, bus.s_wdata, bus.s_wstrb);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
        end else if (!ctrl[0]) begin
            presc <= '0;
        end else if (presc == PW'(PRESCALE - 1)) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    assign tick = ctrl[0] && (presc == PW'(PRESCALE - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl <= 3'b000;
            cmp  <= CMP_RESET;
        end else if (wr_fire) begin
            if (waddr == 2'd0) ctrl <= wr_merged[2:0];
            if (waddr == 2'd2) cmp  <= wr_merged;
        end
    end

    // A software write to COUNT takes priority over the tick update on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 32'h0;
        end else if (wr_fire && (waddr == 2'd1)) begin
            count <= wr_merged;
        end else if (tick) begin
            if ((count == cmp) && ctrl[2]) count <= 32'h0;
            else                           count <= count + 32'd1;
        end
    end

    // Setting the flag wins over a same-edge write-1-to-clear, so no match is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match <= 1'b0;
        end else if (tick && (count == cmp)) begin
            match <= 1'b1;
        end else if (wr_fire && (waddr == 2'd3) && bus.s_wstrb[0] && bus.s_wdata[0]) begin
            match <= 1'b0;
        end
    end

    assign irq           = match & ctrl[1];
    assign bus.s_awready = awready;
    assign bus.s_wready  = wready;
    assign bus.s_bvalid  = bvalid;
    assign bus.s_bresp   = 2'b00;
    assign bus.s_arready = arready;
    assign bus.s_rvalid  = rvalid;
    assign bus.s_rdata   = rdata_q;
    assign bus.s_rresp   = 2'b00;
    assign wr_state_dbg  = (w_state == W_RESP);
    assign rd_state_dbg  = (r_state == R_DATA);
endmodule

// File: tb/tb_axi_lite_timer.sv
// Directed testbench for axi_lite_timer with PRESCALE=4; each scenario task carries its own checks.
module tb_axi_lite_timer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic irq, wr_state_dbg, rd_state_dbg;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    logic wr_irq;

    axi_lite_timer_if bus();

    axi_lite_timer #(.PRESCALE(4), .CMP_RESET(32'hFFFF_FFFF)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .irq(irq),
        .wr_state_dbg(wr_state_dbg),
        .rd_state_dbg(rd_state_dbg)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output int acc);
        int n;
        @(posedge clk); #1;
        bus.s_awaddr = addr; bus.s_awvalid = 1'b1;
        bus.s_wdata = data; bus.s_wstrb = strb; bus.s_wvalid = 1'b1;
        #1;
        n = 0;
        while (!bus.s_awready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        tests++;
        if (bus.s_awready !== 1'b1) begin
            fails++; $display("FAIL write_accept addr=%h awready=%b required 1", addr, bus.s_awready);
        end
        @(posedge clk); #1;
        acc = cyc;
        wr_irq = irq;
        bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0; bus.s_bready = 1'b1;
        @(posedge clk); #1;
        bus.s_bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output int acc);
        int n;
        @(posedge clk); #1;
        bus.s_araddr = addr; bus.s_arvalid = 1'b1;
        n = 0;
        while (!bus.s_arready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        acc = cyc;
        bus.s_arvalid = 1'b0;
        tests++;
        if (bus.s_rvalid !== 1'b1) begin
            fails++; $display("FAIL read_rvalid addr=%h rvalid=%b required 1", addr, bus.s_rvalid);
        end
        data = bus.s_rdata;
        bus.s_rready = 1'b1;
        @(posedge clk); #1;
        bus.s_rready = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        int a;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({bus.s_awready, bus.s_wready, bus.s_bvalid, bus.s_arready, bus.s_rvalid, irq} !== 6'b0) begin
            fails++; $display("FAIL reset_outputs got aw=%b w=%b b=%b ar=%b r=%b irq=%b required all 0",
                bus.s_awready, bus.s_wready, bus.s_bvalid, bus.s_arready, bus.s_rvalid, irq);
        end
        tests++;
        if (bus.s_rdata !== 32'h0) begin
            fails++; $display("FAIL reset_rdata got %h required 0", bus.s_rdata);
        end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bus.s_awaddr = 32'h8; bus.s_wdata = 32'h1234; bus.s_wstrb = 4'hF;
        bus.s_awvalid = 1'b1; bus.s_wvalid = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (bus.s_bvalid !== 1'b1) begin
            fails++; $display("FAIL reset_midwrite_bvalid got %b required 1", bus.s_bvalid);
        end
        rst_n = 1'b0;
        bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
        #1;
        tests++;
        if ({bus.s_bvalid, bus.s_awready, bus.s_arready, irq, wr_state_dbg} !== 5'b0) begin
            fails++; $display("FAIL reset_abandon got b=%b aw=%b ar=%b irq=%b wst=%b required all 0",
                bus.s_bvalid, bus.s_awready, bus.s_arready, irq, wr_state_dbg);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            tests++;
            if (bus.s_bvalid !== 1'b0) begin
                fails++; $display("FAIL reset_no_resp cycle %0d bvalid=%b required 0", i, bus.s_bvalid);
            end
        end
        axi_read(32'h8, d, a);
        tests++;
        if (d !== 32'hFFFF_FFFF) begin
            fails++; $display("FAIL reset_cmp got %h required ffffffff", d);
        end
    endtask

    task automatic test_compare_irq();
        int e0, a, n, seen;
        logic [31:0] d, exp;
        axi_write(32'h4, 32'h0, 4'hF, a);
        axi_write(32'h8, 32'h3, 4'hF, a);
        axi_write(32'hC, 32'h1, 4'hF, a);
        axi_write(32'h0, 32'h3, 4'hF, e0);
        n = 0; seen = -1;
        while (n < 60 && seen < 0) begin
            if (irq === 1'b1) seen = cyc;
            else begin @(posedge clk); #1; n++; end
        end
        tests++;
        if (seen - e0 != 16) begin
            fails++; $display("FAIL cmp_irq_rise got %0d cycles required 16", seen - e0);
        end
        axi_read(32'h4, d, a);
        exp = 32'((a - 1 - e0) / 4);
        tests++;
        if (d !== exp) begin
            fails++; $display("FAIL cmp_count_continues got %h required %h", d, exp);
        end
        axi_read(32'hC, d, a);
        tests++;
        if (d !== 32'h1) begin
            fails++; $display("FAIL cmp_status got %h required 1", d);
        end
    endtask

    task automatic test_autoreload();
        int e0, a, w, n, seen, exp_rise;
        logic [31:0] d, exp;
        axi_write(32'h0, 32'h0, 4'hF, a);
        axi_write(32'hC, 32'h1, 4'hF, a);
        axi_write(32'h4, 32'h0, 4'hF, a);
        axi_write(32'h8, 32'h2, 4'hF, a);
        axi_write(32'h0, 32'h7, 4'hF, e0);
        n = 0; seen = -1;
        while (n < 60 && seen < 0) begin
            if (irq === 1'b1) seen = cyc;
            else begin @(posedge clk); #1; n++; end
        end
        tests++;
        if (seen - e0 != 12) begin
            fails++; $display("FAIL reload_irq_rise got %0d cycles required 12", seen - e0);
        end
        for (int i = 0; i < 3; i++) begin
            axi_read(32'h4, d, a);
            exp = 32'(((a - 1 - e0) / 4) % 3);
            tests++;
            if (d !== exp) begin
                fails++; $display("FAIL reload_count read %0d got %h required %h", i, d, exp);
            end
        end
        axi_write(32'hC, 32'h1, 4'hF, w);
        tests++;
        if (wr_irq !== (((w - e0) % 12 == 0) ? 1'b1 : 1'b0)) begin
            fails++; $display("FAIL reload_w1c_irq got %b after clear edge", wr_irq);
        end
        exp_rise = e0 + 12 * ((w - e0) / 12 + 1);
        n = 0; seen = -1;
        while (n < 60 && seen < 0) begin
            if (irq === 1'b1) seen = cyc;
            else begin @(posedge clk); #1; n++; end
        end
        tests++;
        if (seen != exp_rise) begin
            fails++; $display("FAIL reload_irq_reset got cycle %0d required %0d", seen, exp_rise);
        end
    endtask

    task automatic test_handshake();
        int a;
        logic [31:0] d;
        axi_write(32'h0, 32'h0, 4'hF, a);
        axi_write(32'hC, 32'h1, 4'hF, a);
        @(posedge clk); #1;
        bus.s_awaddr = 32'h8; bus.s_awvalid = 1'b1; bus.s_wvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            tests++;
            if (bus.s_awready !== 1'b0 || bus.s_wready !== 1'b0) begin
                fails++; $display("FAIL hs_aw_only cycle %0d awready=%b wready=%b required 0",
                    i, bus.s_awready, bus.s_wready);
            end
            @(posedge clk); #1;
        end
        bus.s_wdata = 32'h11; bus.s_wstrb = 4'hF; bus.s_wvalid = 1'b1;
        #1;
        tests++;
        if (bus.s_awready !== 1'b1 || bus.s_wready !== 1'b1) begin
            fails++; $display("FAIL hs_both_valid awready=%b wready=%b required 1",
                bus.s_awready, bus.s_wready);
        end
        @(posedge clk); #1;
        bus.s_wdata = 32'h22;
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (bus.s_bvalid !== 1'b1 || bus.s_awready !== 1'b0) begin
                fails++; $display("FAIL hs_bready_low cycle %0d bvalid=%b awready=%b required 1/0",
                    i, bus.s_bvalid, bus.s_awready);
            end
            @(posedge clk); #1;
        end
        bus.s_bready = 1'b1;
        @(posedge clk); #1;
        bus.s_bready = 1'b0;
        tests++;
        if (bus.s_awready !== 1'b1) begin
            fails++; $display("FAIL hs_second_accept awready=%b required 1", bus.s_awready);
        end
        @(posedge clk); #1;
        bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0; bus.s_bready = 1'b1;
        @(posedge clk); #1;
        bus.s_bready = 1'b0;
        bus.s_araddr = 32'h8; bus.s_arvalid = 1'b1;
        @(posedge clk); #1;
        bus.s_arvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (bus.s_rvalid !== 1'b1 || bus.s_rdata !== 32'h22 || bus.s_arready !== 1'b0) begin
                fails++; $display("FAIL hs_rready_low cycle %0d rvalid=%b rdata=%h arready=%b required 1/00000022/0",
                    i, bus.s_rvalid, bus.s_rdata, bus.s_arready);
            end
            @(posedge clk); #1;
        end
        bus.s_rready = 1'b1;
        @(posedge clk); #1;
        bus.s_rready = 1'b0;
        tests++;
        if (bus.s_rvalid !== 1'b0) begin
            fails++; $display("FAIL hs_rvalid_drop got %b required 0", bus.s_rvalid);
        end
        axi_read(32'h8, d, a);
        tests++;
        if (d !== 32'h22) begin
            fails++; $display("FAIL hs_cmp_value got %h required 00000022", d);
        end
    endtask

    task automatic test_wstrb();
        int a;
        logic [31:0] d;
        axi_write(32'h8, 32'h0, 4'hF, a);
        axi_write(32'h8, 32'hAABB_CCDD, 4'b0010, a);
        axi_read(32'h8, d, a);
        tests++;
        if (d !== 32'h0000_CC00) begin
            fails++; $display("FAIL wstrb_cmp got %h required 0000cc00", d);
        end
        axi_write(32'h0, 32'hFFFF_FFFF, 4'h1, a);
        axi_read(32'h0, d, a);
        tests++;
        if (d !== 32'h7) begin
            fails++; $display("FAIL ctrl_unused_bits got %h required 00000007", d);
        end
        axi_write(32'h0, 32'h0, 4'hF, a);
    endtask

    task automatic test_collision();
        int e0, a, t;
        logic [31:0] d, exp;
        axi_write(32'h0, 32'h0, 4'hF, a);
        axi_write(32'h4, 32'h0, 4'hF, a);
        axi_write(32'hC, 32'h1, 4'hF, a);
        axi_write(32'h8, 32'hFFFF_FFFF, 4'hF, a);
        axi_write(32'h0, 32'h1, 4'hF, e0);
        t = e0 + 12;
        while (cyc < t - 2) begin @(posedge clk); #1; end
        axi_write(32'h4, 32'h10, 4'hF, a);
        tests++;
        if (a != t) begin
            fails++; $display("FAIL col_accept_edge got %0d required %0d", a, t);
        end
        axi_read(32'h4, d, a);
        exp = 32'h10 + 32'((a - 1 - t) / 4);
        tests++;
        if (d !== exp) begin
            fails++; $display("FAIL col_count_write got %h required %h", d, exp);
        end
        axi_write(32'h0, 32'h0, 4'hF, a);
        axi_write(32'h4, 32'hFFFF_FFFF, 4'hF, a);
        axi_write(32'h8, 32'h5, 4'hF, a);
        axi_write(32'hC, 32'h1, 4'hF, a);
        axi_write(32'h0, 32'h1, 4'hF, e0);
        while (cyc < e0 + 9) begin @(posedge clk); #1; end
        axi_read(32'h4, d, a);
        exp = 32'hFFFF_FFFF + 32'((a - 1 - e0) / 4);
        tests++;
        if (d !== exp) begin
            fails++; $display("FAIL col_wrap_count got %h required %h", d, exp);
        end
        axi_read(32'hC, d, a);
        tests++;
        if (d !== ((a - 1 >= e0 + 28) ? 32'h1 : 32'h0)) begin
            fails++; $display("FAIL col_no_early_match got %h at cycle %0d", d, a - e0);
        end
        while (cyc < e0 + 30) begin @(posedge clk); #1; end
        axi_read(32'hC, d, a);
        tests++;
        if (d !== 32'h1) begin
            fails++; $display("FAIL col_match_at_5 got %h required 1", d);
        end
        tests++;
        if (irq !== 1'b0) begin
            fails++; $display("FAIL col_irq_masked got %b required 0", irq);
        end
    endtask

    initial begin
        bus.s_awaddr = '0; bus.s_awprot = '0; bus.s_awvalid = 1'b0;
        bus.s_wdata = '0; bus.s_wstrb = '0; bus.s_wvalid = 1'b0; bus.s_bready = 1'b0;
        bus.s_araddr = '0; bus.s_arprot = '0; bus.s_arvalid = 1'b0; bus.s_rready = 1'b0;
        wr_irq = 1'b0;
        test_reset();
        test_compare_irq();
        test_autoreload();
        test_handshake();
        test_wstrb();
        test_collision();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
